cdc_xfer_arbiter: RTL and testbench
===================================

CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, payload bits per requester.
- ID_W, $clog2(N_REQ), requester tag width.
- TIMEOUT_CYC, 1024, stall cycles before the timeout flag sets.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; the block shall have one clock only.
- rst_n, in, 1, reset, asynchronous and active-low.
- req_valid, in, N_REQ, per-requester transfer request.
- req_data, in, N_REQ*WIDTH, payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready, out, N_REQ, one-hot accept pulse.
- ch_data, out, ID_W+WIDTH, to the handshake channel source data: {grant_id, payload}.
- ch_valid, out, 1, to the channel source valid.
- ch_ready, in, 1, from the channel source ready (high = idle).
- grant_id, out, ID_W, index of the requester currently owning the channel.
- busy, out, 1, high when state != IDLE.
- timeout_err, out, 1, sticky stall flag.
- err_clr, in, 1, clears timeout_err.

Function
REQ-003 The FSM shall have three states: IDLE, ISSUE and WAIT.
REQ-004 In IDLE with any req_valid set:
- select winner g by round-robin, starting at index (last_grant+1) mod N_REQ;
- assert req_ready[g] for exactly that cycle;
- register req_data[g] and g;
- set last_grant to g;
- go to ISSUE.
REQ-005 A requester shall be considered accepted only on req_valid[i] && req_ready[i]; holding req_valid after acceptance is a new request.
REQ-006 In ISSUE, ch_valid shall be 1 and ch_data stable. On ch_ready=1 the transfer completes and the FSM goes to WAIT.
REQ-007 Latency: ch_valid shall first assert one cycle after the req_ready pulse.
REQ-008 In WAIT, ch_valid shall be 0. The first WAIT cycle shall be ignored, because channel ready drops one cycle after a toggle. From the second WAIT cycle on, ch_ready=1 returns the FSM to IDLE.
REQ-009 In the IDLE cycle following WAIT, arbitration shall occur. Back-to-back transfers therefore cost at least 3 cycles plus the channel round trip.
REQ-010 With no req_valid set, IDLE shall hold, and req_ready and ch_valid shall be 0.
REQ-011 Stall counter:
- counts cycles in ISSUE or WAIT with ch_ready=0;
- clears on every return to IDLE;
- saturates at TIMEOUT_CYC.
REQ-012 timeout_err shall set when the stall counter reaches TIMEOUT_CYC. It shall stay set until err_clr=1. If set and clear occur in the same cycle, set wins. A timeout shall not abort the transfer.
REQ-013 Round-robin shall guarantee that a requester with req_valid held high is granted within N_REQ arbitrations.
REQ-014 Changes to req_data or req_valid after acceptance shall not alter ch_data.

Reset
REQ-015 On reset assertion, outputs shall take these values asynchronously:
- state = IDLE;
- last_grant = N_REQ-1, so index 0 has first priority;
- ch_valid, req_ready, busy, timeout_err = 0;
- ch_data, grant_id and the stall counter = 0.
REQ-016 Reset mid-transfer shall abandon the transfer. No req_ready pulse shall be reissued for it.

Structure
REQ-017 The state enum, along with the ID_W derivation function and the channel-word packing helper, shall reside in the shared package cdc_pkg.
REQ-018 The round-robin selection shall be one combinational sub-module, cdc_rr_pick, with pointer and request inputs and one-hot plus index outputs.
REQ-019 ch_valid, ch_data and req_ready shall be driven from registers or from state decode only, with no combinational path from ch_ready.

Verification
REQ-020 The bench shall cover these directed scenarios:
- Single transfer: req_valid=4'b0100 with data 0xDEADBEEF, and ch_ready returning after 6 cycles -> one req_ready[2] pulse; ch_data={2'd2,0xDEADBEEF} one cycle later; busy back to 0 after WAIT.
- Fairness: all four req_valid held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
- Data isolation: req_data changed in the cycle after acceptance -> ch_data unchanged through ISSUE.
- Timeout: TIMEOUT_CYC=16 with ch_ready held 0 -> timeout_err=1 after 16 stall cycles; transfer completes when ready returns; err_clr and set in the same cycle -> flag stays 1.
- Reset in ISSUE: rst_n=0 -> ch_valid=0 immediately; after release, the first grant goes to requester 0.
- Ready glitch: ch_ready high during the first WAIT cycle -> FSM stays in WAIT.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the transfer arbiter: FSM state encoding,
// tag-width derivation and packing of the {grant_id, payload} channel word.
package cdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   // Widest channel word the packing helper can build; callers cast the result down.
   localparam int unsigned CH_MAX_W = 1024;

   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [CH_MAX_W-1:0] pack_ch(input logic [CH_MAX_W-1:0] id,
                                                   input logic [CH_MAX_W-1:0] payload,
                                                   input int unsigned         width);
      return (id << width) | payload;
   endfunction

endpackage

// File: rtl/cdc_xfer_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after start_i,
// wrapping modulo N_REQ.
module cdc_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [ID_W-1:0]  start_i,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] gnt_oh_o,
   output logic [ID_W-1:0]  gnt_idx_o,
   output logic             any_o
);

   logic [ID_W-1:0] cand;

   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ID_W'((int'(start_i) + k) % N_REQ);
         if (!any_o && req_i[cand]) begin
            any_o          = 1'b1;
            gnt_oh_o[cand] = 1'b1;
            gnt_idx_o      = cand;
         end
      end
   end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter feeding one handshake-channel source; tags each payload
// with the winning requester index and flags channel stalls.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | arbitrate; pulse req_ready for the winner and capture its data
//   ST_ISSUE | ch_valid high, waiting for ch_ready to complete the transfer
//   ST_WAIT  | channel settling; first cycle ignored, then ch_ready -> IDLE
module cdc_xfer_arbiter
   import cdc_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 32,
   parameter int ID_W        = id_width(N_REQ),
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic [ID_W+WIDTH-1:0]  ch_data,
   output logic                   ch_valid,
   input  logic                   ch_ready,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy,
   output logic                   timeout_err,
   input  logic                   err_clr
);

   localparam int              CH_W     = ID_W + WIDTH;
   localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(TIMEOUT_CYC);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [ID_W-1:0]    gid_q, gid_d;
   logic [CH_W-1:0]    ch_data_q, ch_data_d;
   logic               wait_first_q, wait_first_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic               err_q, err_d;

   logic [ID_W-1:0]    start_idx;
   logic [ID_W-1:0]    pick_idx;
   logic [N_REQ-1:0]   pick_oh;
   logic               pick_any;
   logic [WIDTH-1:0]   pay_arr [N_REQ];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         pay_arr[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   assign start_idx = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

   cdc_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .start_i   (start_idx),
      .req_i     (req_valid),
      .gnt_oh_o  (pick_oh),
      .gnt_idx_o (pick_idx),
      .any_o     (pick_any)
   );

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      gid_d        = gid_q;
      ch_data_d    = ch_data_q;
      wait_first_d = wait_first_q;
      req_ready    = '0;
      stall_d      = stall_q;
      err_d        = err_q;

      case (state_q)
         ST_IDLE: begin
            // rst_n gate keeps the accept pulse low while reset is held.
            if (pick_any && rst_n) begin
               req_ready = pick_oh;
               last_d    = pick_idx;
               gid_d     = pick_idx;
               ch_data_d = CH_W'(pack_ch(CH_MAX_W'(pick_idx), CH_MAX_W'(pay_arr[pick_idx]),
                                         WIDTH));
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ch_ready) begin
               state_d      = ST_WAIT;
               wait_first_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (ch_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && !ch_ready && stall_q != T_MAX) begin
         stall_d = stall_q + 1'b1;
      end
      if (state_d == ST_IDLE) begin
         stall_d = '0;
      end

      if (err_clr) begin
         err_d = 1'b0;
      end
      if (stall_d == T_MAX) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_q       <= LAST_IDX;
         gid_q        <= '0;
         ch_data_q    <= '0;
         wait_first_q <= 1'b0;
         stall_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         gid_q        <= gid_d;
         ch_data_q    <= ch_data_d;
         wait_first_q <= wait_first_d;
         stall_q      <= stall_d;
         err_q        <= err_d;
      end
   end

   assign ch_valid    = (state_q == ST_ISSUE);
   assign busy        = (state_q != ST_IDLE);
   assign ch_data     = ch_data_q;
   assign grant_id    = gid_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Self-checking bench for cdc_xfer_arbiter: directed scenarios plus randomized
// transfers checked against a round-robin reference model.
module tb_cdc_xfer_arbiter;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int IDW = 2;
   localparam int T   = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_ready;
   logic [IDW+W-1:0] ch_data;
   logic             ch_valid;
   logic             ch_ready;
   logic [IDW-1:0]   grant_id;
   logic             busy;
   logic             timeout_err;
   logic             err_clr;

   int n_vec = 0;
   int n_err = 0;
   int model_last;

   always #5 clk = ~clk;

   cdc_xfer_arbiter #(
      .N_REQ       (N),
      .WIDTH       (W),
      .TIMEOUT_CYC (T)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .ch_data     (ch_data),
      .ch_valid    (ch_valid),
      .ch_ready    (ch_ready),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   // Reference: scan requesters starting just after the last winner.
   function automatic int rr_pick(input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (model_last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
   endtask

   task automatic do_xfer(input logic [N-1:0] v, input bit hold, input int rdy_dly,
                          input int wait_dly, input bit glitch, output int gid);
      int               g;
      logic [N-1:0]     exp_rdy;
      logic [IDW+W-1:0] exp_w;
      req_valid = v;
      ch_ready  = 1'b0;
      #1;
      g = rr_pick(v);
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL accept_pulse: got %b expected %b", req_ready, exp_rdy);
      end
      exp_w = {IDW'(g), req_data[g*W +: W]};
      model_last = g;
      tick;
      if (!hold) req_valid = '0;
      rand_data();
      gid = int'(grant_id);
      n_vec++;
      if (ch_valid !== 1'b1 || ch_data !== exp_w || grant_id !== IDW'(g) || busy !== 1'b1) begin
         n_err++;
         $display("FAIL issue_start: got v=%b d=%h id=%0d busy=%b expected v=1 d=%h id=%0d busy=1",
                  ch_valid, ch_data, grant_id, busy, exp_w, g);
      end
      n_vec++;
      if (req_ready !== '0) begin
         n_err++;
         $display("FAIL single_pulse: got %b expected 0", req_ready);
      end
      for (int i = 0; i < rdy_dly; i++) begin
         tick;
         rand_data();
         n_vec++;
         if (ch_valid !== 1'b1 || ch_data !== exp_w) begin
            n_err++;
            $display("FAIL issue_stable: got v=%b d=%h expected v=1 d=%h", ch_valid, ch_data, exp_w);
         end
      end
      ch_ready = 1'b1;
      tick;
      n_vec++;
      if (ch_valid !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL wait_entry: got v=%b busy=%b expected v=0 busy=1", ch_valid, busy);
      end
      ch_ready = glitch;
      tick;
      n_vec++;
      if (busy !== 1'b1 || ch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wait_first: got busy=%b v=%b expected busy=1 v=0", busy, ch_valid);
      end
      ch_ready = 1'b0;
      repeat (wait_dly) tick;
      ch_ready = 1'b1;
      tick;
      n_vec++;
      if (busy !== 1'b0 || ch_valid !== 1'b0 || timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL idle_return: got busy=%b v=%b terr=%b expected 0 0 0",
                  busy, ch_valid, timeout_err);
      end
      ch_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = '0; req_data = '0; ch_ready = 1'b0; err_clr = 1'b0;
      #3;
      n_vec++;
      if (req_ready !== '0 || ch_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 ||
          ch_data !== '0 || grant_id !== '0) begin
         n_err++;
         $display("FAIL reset_values: got rdy=%b v=%b busy=%b terr=%b d=%h id=%0d expected all 0",
                  req_ready, ch_valid, busy, timeout_err, ch_data, grant_id);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_last = N - 1;
      tick;
   endtask

   task automatic test_idle;
      req_valid = '0;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_vec++;
         if (req_ready !== '0 || ch_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: got rdy=%b v=%b busy=%b expected 0 0 0", req_ready, ch_valid, busy);
         end
      end
   endtask

   task automatic test_fairness;
      int gid;
      rand_data();
      for (int i = 0; i < 8; i++) begin
         do_xfer(4'hF, 1'b1, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, gid);
         n_vec++;
         if (gid !== i % N) begin
            n_err++;
            $display("FAIL fairness_order: got %0d expected %0d", gid, i % N);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_single;
      int gid;
      rand_data();
      req_data[2*W +: W] = 32'hDEADBEEF;
      do_xfer(4'b0100, 1'b0, 5, 1, 1'b0, gid);
      n_vec++;
      if (gid !== 2) begin
         n_err++;
         $display("FAIL single_grant: got %0d expected 2", gid);
      end
   endtask

   task automatic test_glitch;
      int gid;
      rand_data();
      do_xfer(4'b0001, 1'b0, 2, 0, 1'b1, gid);
      do_xfer(4'b1010, 1'b0, 0, 3, 1'b1, gid);
   endtask

   task automatic test_timeout;
      logic [N-1:0] exp_rdy;
      int           g;
      rand_data();
      req_valid = 4'b0010;
      #1;
      g = rr_pick(req_valid);
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL to_accept: got %b expected %b", req_ready, exp_rdy);
      end
      model_last = g;
      tick;
      req_valid = '0;
      for (int k = 1; k <= 20; k++) begin
         err_clr = (k == 18);
         tick;
         n_vec++;
         if (timeout_err !== (k >= T) || ch_valid !== 1'b1) begin
            n_err++;
            $display("FAIL to_stall%0d: got terr=%b v=%b expected terr=%b v=1",
                     k, timeout_err, ch_valid, (k >= T));
         end
      end
      err_clr = 1'b0;
      ch_ready = 1'b1;
      tick;
      n_vec++;
      if (ch_valid !== 1'b0 || timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL to_complete: got v=%b terr=%b expected v=0 terr=1", ch_valid, timeout_err);
      end
      tick;
      tick;
      n_vec++;
      if (busy !== 1'b0 || timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL to_sticky: got busy=%b terr=%b expected busy=0 terr=1", busy, timeout_err);
      end
      ch_ready = 1'b0;
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      n_vec++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL to_clear: got %b expected 0", timeout_err);
      end
   endtask

   task automatic test_reset_in_issue;
      int gid;
      rand_data();
      req_valid = 4'b1000;
      tick;
      n_vec++;
      if (ch_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre: got v=%b expected 1", ch_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (ch_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || ch_data !== '0 ||
          grant_id !== '0) begin
         n_err++;
         $display("FAIL rst_async: got v=%b busy=%b rdy=%b d=%h id=%0d expected all 0",
                  ch_valid, busy, req_ready, ch_data, grant_id);
      end
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_last = N - 1;
      tick;
      do_xfer(4'hF, 1'b0, 1, 1, 1'b0, gid);
      n_vec++;
      if (gid !== 0) begin
         n_err++;
         $display("FAIL rst_first_grant: got %0d expected 0", gid);
      end
   endtask

   task automatic test_random;
      int gid;
      for (int i = 0; i < 30; i++) begin
         rand_data();
         do_xfer(N'($urandom_range(1, 15)), 1'b0, $urandom_range(0, 6), $urandom_range(0, 5),
                 1'($urandom_range(0, 1)), gid);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_fairness();
      test_single();
      test_glitch();
      test_timeout();
      test_reset_in_issue();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
